frame_stack: RTL
================

// Module: frame_stack
// PURPOSE
//   Parametrised operand stack with a built-in call-frame stack. It is the successor of the single-limit stack.
//   CALL/RETURN maintain the frame base in hardware, replacing the externally driven underflow limit.
//   RETURN compacts the result values down to the frame base over multiple cycles.
//   Used by the wasm core for function locals, args and results.
// PARAMETERS
//   WIDTH        8  data bits per entry
//   DEPTH        4  log2 of stack entries (MAX = 1<<DEPTH)
//   FRAME_DEPTH  2  log2 of nested frames (FMAX = 1<<FRAME_DEPTH)
// PORTS
//   clk          in   1            clock, all state on rising edge
//   reset        in   1            synchronous, active-high
//   op           in   3            0 NONE,1 PUSH,2 POP,3 REPLACE,4 CALL,5 RETURN,6 GET,7 SET
//   data         in   WIDTH        PUSH/REPLACE/SET value
//   offset       in   DEPTH+1      CALL arg count / RETURN result count / GET-SET local index
//   index        out  DEPTH+1      entries in use (absolute)
//   base         out  DEPTH+1      current frame base
//   frame_level  out  FRAME_DEPTH+1  frames in use
//   out,out1,out2 out WIDTH        mem[index-1..index-3]; entries below base or <0 read 0
//   getter       out  WIDTH        value latched by GET
//   busy         out  1            RETURN copy in progress
//   status       out  2            0 NONE,1 EMPTY(index==base),2 FULL(index==MAX)
//   error        out  3            0 NONE,1 UNDERFLOW,2 OVERFLOW,3 BAD_OFFSET,4 FRAME_OVF,5 FRAME_UNF,6 BUSY
// BEHAVIOUR
//   - Reset: index=base=frame_level=0, busy=0, getter=0, error=0, status=EMPTY. Memory is not cleared.
//     Reset overrides any op and aborts a RETURN copy mid-flight.
//   - The op is sampled at posedge. Results are visible after that edge (1-cycle latency).
//   - error is valid for one cycle after the failing op, then 0. On any error, state is unchanged.
//   - PUSH: index==MAX -> OVERFLOW. Otherwise mem[index]=data and index+1.
//   - POP: index==base -> UNDERFLOW. A frame's args cannot be popped past base.
//   - REPLACE: index==base -> UNDERFLOW. Otherwise mem[index-1]=data.
//   - GET/SET: base+offset >= index -> BAD_OFFSET.
//     Otherwise getter<=mem[base+offset] (GET), or mem[base+offset]<=data (SET).
//   - CALL: offset > index-base -> UNDERFLOW. frame_level==FMAX -> FRAME_OVF.
//     Otherwise push the old base to the frame memory, then base=index-offset and frame_level+1.
//   - RETURN: frame_level==0 -> FRAME_UNF. offset > index-base -> UNDERFLOW.
//     R=offset. src=index-R, dst=base.
//     - FSM IDLE->COPY when R>0. Each COPY cycle: mem[dst+k]=mem[src+k], k=0..R-1. busy=1 for R cycles.
//     - Last copy cycle -> IDLE: index=base+R, base=popped base, frame_level-1, busy=0.
//     - R==0: single cycle, no busy.
//   - Any op other than NONE while busy: error=BUSY, op discarded, copy continues.
//   - Arithmetic is unsigned DEPTH+1 bits. Comparisons run before the update, so no wrap is possible.
//   - Simultaneous reset+op: reset wins.
// CONFIGURATION
//   FRAME_STACK_LOCALS_ZERO_EN defined:
//     - CALL uses data[DEPTH:0] = L extra locals.
//     - FSM state ZERO writes 0 to mem[index..index+L-1], one per cycle, with busy=1.
//     - Then index+=L. If index+L>MAX -> OVERFLOW, with no frame pushed.
//   FRAME_STACK_LOCALS_ZERO_EN undefined: CALL ignores data. No ZERO state.
// TESTING (WIDTH=8, DEPTH=2, FRAME_DEPTH=1: MAX=4, FMAX=2)
//   1. reset -> status EMPTY, index 0, frame_level 0, busy 0. Then POP -> error UNDERFLOW, index 0.
//   2. PUSH 1,2,3,4 -> status FULL, out=4, out1=3, out2=2. PUSH 5 -> error OVERFLOW, out still 4.
//   3. Empty. PUSH 10h,11h,12h. CALL offset=2 -> base 1, index 3, frame_level 1, status NONE.
//      GET offset=0 -> getter 11h. SET offset=1 data=22h -> out 22h. GET offset=2 -> BAD_OFFSET.
//   4. From 3: PUSH 33h, RETURN offset=1 -> busy=1 for 1 cycle.
//      Then index 2, base 0, frame_level 0, out 33h, out1 10h.
//   5. CALL, CALL -> frame_level 2. CALL -> FRAME_OVF.
//      RETURN 0 twice -> level 0. RETURN -> FRAME_UNF.
//   6. Push 4 entries, CALL 3, RETURN 3. PUSH while busy -> error BUSY, ignored.
//      reset in 2nd copy cycle -> next cycle busy 0, index 0.
//   Rerun tests 3-4 with FRAME_STACK_LOCALS_ZERO_EN, CALL data=1 -> busy 1 cycle, out 00h, index+1.

Source files
------------

// File: rtl/frame_stack.sv
// frame_stack: operand stack with a hardware call-frame stack and multi-cycle RETURN compaction.
// Optional build macro FRAME_STACK_LOCALS_ZERO_EN: CALL also allocates data[DEPTH:0] zeroed locals.
module frame_stack #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FRAME_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             op,
    input  logic [WIDTH-1:0]       data,
    input  logic [DEPTH:0]         offset,
    output logic [DEPTH:0]         index,
    output logic [DEPTH:0]         base,
    output logic [FRAME_DEPTH:0]   frame_level,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       out1,
    output logic [WIDTH-1:0]       out2,
    output logic [WIDTH-1:0]       getter,
    output logic                   busy,
    output logic [1:0]             status,
    output logic [2:0]             error
);
    localparam int unsigned IW   = DEPTH + 1;
    localparam int unsigned FW   = FRAME_DEPTH + 1;
    localparam int unsigned MAX  = 1 << DEPTH;
    localparam int unsigned FMAX = 1 << FRAME_DEPTH;

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_CALL    = 3'd4;
    localparam logic [2:0] OP_RETURN  = 3'd5;
    localparam logic [2:0] OP_GET     = 3'd6;
    localparam logic [2:0] OP_SET     = 3'd7;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
    localparam logic [2:0] ERR_BAD_OFF   = 3'd3;
    localparam logic [2:0] ERR_FRAME_OVF = 3'd4;
    localparam logic [2:0] ERR_FRAME_UNF = 3'd5;
    localparam logic [2:0] ERR_BUSY      = 3'd6;

    localparam logic [1:0] ST_NONE  = 2'd0;
    localparam logic [1:0] ST_EMPTY = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

`ifdef FRAME_STACK_LOCALS_ZERO_EN
    localparam int unsigned XW = IW + 1;
    typedef enum logic [1:0] {S_IDLE, S_COPY, S_ZERO} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COPY} state_t;
`endif

    state_t state, state_n;

    logic [WIDTH-1:0]       mem  [MAX];
    logic [IW-1:0]          fmem [FMAX];

    logic [IW-1:0]          index_n, base_n, cnt, cnt_n, rlen, rlen_n, used, loc;
    logic [IW-1:0]          pos0, pos1, pos2;
    logic [DEPTH-1:0]       src, src_n, dst, dst_n, mem_addr;
    logic [FW-1:0]          level_n;
    logic [FRAME_DEPTH-1:0] ftop;
    logic [WIDTH-1:0]       getter_n, mem_wdata;
    logic [2:0]             error_n;
    logic [1:0]             status_n;
    logic                   mem_we, frame_we;

    // Next-state, datapath controls and error decode
    always_comb begin
        state_n   = state;
        index_n   = index;
        base_n    = base;
        level_n   = frame_level;
        getter_n  = getter;
        error_n   = ERR_NONE;
        cnt_n     = cnt;
        rlen_n    = rlen;
        src_n     = src;
        dst_n     = dst;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        frame_we  = 1'b0;
        used      = index - base;
        loc       = base + offset;
        ftop      = FRAME_DEPTH'(frame_level - FW'(1));

        case (state)
            S_COPY: begin
                if (op != OP_NONE) error_n = ERR_BUSY;
                mem_we    = 1'b1;
                mem_addr  = dst;
                mem_wdata = mem[src];
                src_n     = src + DEPTH'(1);
                dst_n     = dst + DEPTH'(1);
                cnt_n     = cnt - IW'(1);
                if (cnt == IW'(1)) begin
                    state_n = S_IDLE;
                    index_n = base + rlen;
                    base_n  = fmem[ftop];
                    level_n = frame_level - FW'(1);
                end
            end
`ifdef FRAME_STACK_LOCALS_ZERO_EN
            S_ZERO: begin
                if (op != OP_NONE) error_n = ERR_BUSY;
                mem_we    = 1'b1;
                mem_addr  = DEPTH'(index);
                mem_wdata = '0;
                index_n   = index + IW'(1);
                cnt_n     = cnt - IW'(1);
                if (cnt == IW'(1)) state_n = S_IDLE;
            end
`endif
            default: begin
                case (op)
                    OP_PUSH: begin
                        if (index == IW'(MAX)) error_n = ERR_OVERFLOW;
                        else begin
                            mem_we    = 1'b1;
                            mem_addr  = DEPTH'(index);
                            mem_wdata = data;
                            index_n   = index + IW'(1);
                        end
                    end
                    OP_POP: begin
                        if (used == '0) error_n = ERR_UNDERFLOW;
                        else index_n = index - IW'(1);
                    end
                    OP_REPLACE: begin
                        if (used == '0) error_n = ERR_UNDERFLOW;
                        else begin
                            mem_we    = 1'b1;
                            mem_addr  = DEPTH'(index - IW'(1));
                            mem_wdata = data;
                        end
                    end
                    OP_GET: begin
                        if (offset >= used) error_n = ERR_BAD_OFF;
                        else getter_n = mem[DEPTH'(loc)];
                    end
                    OP_SET: begin
                        if (offset >= used) error_n = ERR_BAD_OFF;
                        else begin
                            mem_we    = 1'b1;
                            mem_addr  = DEPTH'(loc);
                            mem_wdata = data;
                        end
                    end
                    OP_CALL: begin
                        if (offset > used) error_n = ERR_UNDERFLOW;
                        else if (frame_level == FW'(FMAX)) error_n = ERR_FRAME_OVF;
`ifdef FRAME_STACK_LOCALS_ZERO_EN
                        else if ((XW'(index) + XW'(data[DEPTH:0])) > XW'(MAX)) error_n = ERR_OVERFLOW;
`endif
                        else begin
                            frame_we = 1'b1;
                            base_n   = index - offset;
                            level_n  = frame_level + FW'(1);
`ifdef FRAME_STACK_LOCALS_ZERO_EN
                            if (data[DEPTH:0] != '0) begin
                                state_n = S_ZERO;
                                cnt_n   = data[DEPTH:0];
                            end
`endif
                        end
                    end
                    OP_RETURN: begin
                        if (frame_level == '0) error_n = ERR_FRAME_UNF;
                        else if (offset > used) error_n = ERR_UNDERFLOW;
                        else if (offset == '0) begin
                            index_n = base;
                            base_n  = fmem[ftop];
                            level_n = frame_level - FW'(1);
                        end else begin
                            state_n = S_COPY;
                            cnt_n   = offset;
                            rlen_n  = offset;
                            src_n   = DEPTH'(index - offset);
                            dst_n   = DEPTH'(base);
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        if (index_n == base_n)          status_n = ST_EMPTY;
        else if (index_n == IW'(MAX))   status_n = ST_FULL;
        else                            status_n = ST_NONE;
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            index       <= '0;
            base        <= '0;
            frame_level <= '0;
            getter      <= '0;
            error       <= ERR_NONE;
            status      <= ST_EMPTY;
            busy        <= 1'b0;
            cnt         <= '0;
            rlen        <= '0;
            src         <= '0;
            dst         <= '0;
        end else begin
            state       <= state_n;
            index       <= index_n;
            base        <= base_n;
            frame_level <= level_n;
            getter      <= getter_n;
            error       <= error_n;
            status      <= status_n;
            busy        <= (state_n != S_IDLE);
            cnt         <= cnt_n;
            rlen        <= rlen_n;
            src         <= src_n;
            dst         <= dst_n;
        end
    end

    // Operand and frame storage; never cleared, writes suppressed under reset
    always_ff @(posedge clk) begin
        if (!reset && mem_we)   mem[mem_addr] <= mem_wdata;
        if (!reset && frame_we) fmem[FRAME_DEPTH'(frame_level)] <= base;
    end

    // Top-of-stack views; slots below the frame base or below zero read 0
    always_comb begin
        pos0 = index - IW'(1);
        pos1 = index - IW'(2);
        pos2 = index - IW'(3);
        out  = (index >= IW'(1) && pos0 >= base) ? mem[DEPTH'(pos0)] : '0;
        out1 = (index >= IW'(2) && pos1 >= base) ? mem[DEPTH'(pos1)] : '0;
        out2 = (index >= IW'(3) && pos2 >= base) ? mem[DEPTH'(pos2)] : '0;
    end

endmodule
